// File: rtl/lif_pkg.sv
// lif_pkg: FSM encoding, reset-mode constants and elaboration width checks for the LIF engine
`ifndef LIF_PKG_SV
`define LIF_PKG_SV
`define LIF_CHECK_WIDTH(label, cond, msg) if (!(cond)) begin : label $error(msg); end
package lif_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INTEG = 3'd1,
        ST_LEAK  = 3'd2,
        ST_FIRE  = 3'd3,
        ST_OUT   = 3'd4
    } lif_state_e;
    localparam logic [1:0] RST_ABS  = 2'd0;
    localparam logic [1:0] RST_LIN  = 2'd1;
    localparam logic [1:0] RST_NONE = 2'd2;
endpackage
`endif

// File: rtl/lif_sat_add.sv
// lif_sat_add: signed adder that clamps to the PW-bit range instead of wrapping
module lif_sat_add #(
    parameter int PW = 9,
    parameter int AW = PW,
    parameter int BW = PW
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    output logic signed [PW-1:0] y
);
    logic signed [PW:0] sum;
    // one guard bit catches overflow; clamp toward the sign of the true result
    always_comb begin
        sum = (PW+1)'(a) + (PW+1)'(b);
        y   = (sum[PW] ^ sum[PW-1]) ? {sum[PW], {(PW-1){~sum[PW]}}} : sum[PW-1:0];
    end
endmodule

// File: rtl/lif_neuron_engine.sv
// lif_neuron_engine: handshaked leaky integrate-and-fire engine, one neuron job at a time
module lif_neuron_engine
    import lif_pkg::*;
#(
    parameter int LEAK_WIDTH      = 9,
    parameter int WEIGHT_WIDTH    = 9,
    parameter int THRESHOLD_WIDTH = 9,
    parameter int POTENTIAL_WIDTH = 9,
    parameter int NUM_WEIGHTS     = 4,
    parameter int NEG_RESET_MODE  = 0,
    localparam int TYPE_WIDTH     = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       cfg_valid,
    output logic                                       cfg_ready,
    input  logic signed [POTENTIAL_WIDTH-1:0]          cfg_potential,
    input  logic signed [LEAK_WIDTH-1:0]               cfg_leak,
    input  logic [WEIGHT_WIDTH*NUM_WEIGHTS-1:0]        cfg_weights,
    input  logic [THRESHOLD_WIDTH-1:0]                 cfg_pos_threshold,
    input  logic [THRESHOLD_WIDTH-1:0]                 cfg_neg_threshold,
    input  logic signed [POTENTIAL_WIDTH-1:0]          cfg_reset_potential,
    input  logic [1:0]                                 cfg_reset_mode,
    input  logic                                       ax_valid,
    output logic                                       ax_ready,
    input  logic [TYPE_WIDTH-1:0]                      ax_type,
    input  logic                                       ax_spike,
    input  logic                                       ax_last,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic signed [POTENTIAL_WIDTH-1:0]          out_potential,
    output logic                                       out_spike
);
    localparam int PW = POTENTIAL_WIDTH;
    localparam int WW = WEIGHT_WIDTH;
    localparam int TW = THRESHOLD_WIDTH;
    localparam int NW = NUM_WEIGHTS;

    `LIF_CHECK_WIDTH(g_bad_weight_width, WW <= PW, "WEIGHT_WIDTH must not exceed POTENTIAL_WIDTH")
    `LIF_CHECK_WIDTH(g_bad_threshold_width, TW <= PW, "THRESHOLD_WIDTH must not exceed POTENTIAL_WIDTH")

    function automatic logic signed [PW-1:0] clamp(input logic signed [PW:0] x);
        return (x[PW] ^ x[PW-1]) ? {x[PW], {(PW-1){~x[PW]}}} : x[PW-1:0];
    endfunction

    lif_state_e                state_q, state_d;
    logic signed [PW-1:0]      acc_q, acc_d, rst_pot_q, rst_pot_d, out_pot_q, out_pot_d;
    logic signed [LEAK_WIDTH-1:0] leak_q, leak_d;
    logic [WW*NW-1:0]          weights_q, weights_d;
    logic [TW-1:0]             pos_th_q, pos_th_d, neg_th_q, neg_th_d;
    logic [1:0]                mode_q, mode_d;
    logic                      out_spike_q, out_spike_d;
    logic signed [WW-1:0]      w_sel;
    logic signed [PW-1:0]      add_b, sum, fire_pot;
    logic signed [PW:0]        p_x, pos_x, neg_x, lin_x;
    logic                      fire_spike;

    // weight lookup for the current beat; w0 sits in the MSBs
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NW; i++)
            if (ax_type == TYPE_WIDTH'(i)) w_sel = weights_q[(NW-1-i)*WW +: WW];
        add_b = (state_q == ST_LEAK) ? PW'(leak_q) : PW'(w_sel);
    end

    lif_sat_add #(.PW(PW)) u_add (.a(acc_q), .b(add_b), .y(sum));

    // threshold compare and reset selection on the leaked potential
    always_comb begin
        p_x        = (PW+1)'(acc_q);
        pos_x      = $signed((PW+1)'(pos_th_q));
        neg_x      = -$signed((PW+1)'(neg_th_q));
        lin_x      = p_x - pos_x;
        fire_spike = p_x >= pos_x;
        fire_pot   = fire_spike ? ((mode_q == RST_LIN) ? clamp(lin_x) : (mode_q == RST_NONE) ? acc_q : rst_pot_q)
                   : (p_x < neg_x) ? ((NEG_RESET_MODE != 0) ? rst_pot_q : clamp(neg_x)) : acc_q;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = cfg_valid ? ST_INTEG : ST_IDLE;
            ST_INTEG: state_d = (ax_valid && ax_last) ? ST_LEAK : ST_INTEG;
            ST_LEAK:  state_d = ST_FIRE;
            ST_FIRE:  state_d = ST_OUT;
            ST_OUT:   state_d = out_ready ? ST_IDLE : ST_OUT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // handshake outputs decoded from registered state only
    always_comb begin
        cfg_ready     = state_q == ST_IDLE;
        ax_ready      = state_q == ST_INTEG;
        out_valid     = state_q == ST_OUT;
        out_potential = out_pot_q;
        out_spike     = out_spike_q;
    end

    // datapath next values: latch job, integrate beats, leak, then capture result
    always_comb begin
        leak_d      = leak_q;
        weights_d   = weights_q;
        pos_th_d    = pos_th_q;
        neg_th_d    = neg_th_q;
        rst_pot_d   = rst_pot_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        out_pot_d   = out_pot_q;
        out_spike_d = out_spike_q;
        if (state_q == ST_IDLE && cfg_valid) begin
            leak_d    = cfg_leak;
            weights_d = cfg_weights;
            pos_th_d  = cfg_pos_threshold;
            neg_th_d  = cfg_neg_threshold;
            rst_pot_d = cfg_reset_potential;
            mode_d    = cfg_reset_mode;
            acc_d     = cfg_potential;
        end
        if ((state_q == ST_INTEG && ax_valid && ax_spike) || state_q == ST_LEAK) acc_d = sum;
        if (state_q == ST_FIRE) begin
            out_pot_d   = fire_pot;
            out_spike_d = fire_spike;
        end
    end

    // datapath registers; reset clears results and job context
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leak_q      <= '0;
            weights_q   <= '0;
            pos_th_q    <= '0;
            neg_th_q    <= '0;
            rst_pot_q   <= '0;
            mode_q      <= '0;
            acc_q       <= '0;
            out_pot_q   <= '0;
            out_spike_q <= 1'b0;
        end else begin
            leak_q      <= leak_d;
            weights_q   <= weights_d;
            pos_th_q    <= pos_th_d;
            neg_th_q    <= neg_th_d;
            rst_pot_q   <= rst_pot_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            out_pot_q   <= out_pot_d;
            out_spike_q <= out_spike_d;
        end
    end
endmodule

// File: tb/tb_lif_neuron_engine.sv
// tb_lif_neuron_engine: table-driven jobs with a result scoreboard plus backpressure and reset sequences
module tb_lif_neuron_engine;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0, cfg_ready;
    logic signed [8:0] cfg_potential = '0, cfg_leak = '0, cfg_reset_potential = '0;
    logic [35:0]       cfg_weights = '0;
    logic [8:0]        cfg_pos_threshold = '0, cfg_neg_threshold = '0;
    logic [1:0]        cfg_reset_mode = '0;
    logic              ax_valid = 1'b0, ax_ready, ax_spike = 1'b0, ax_last = 1'b0;
    logic [1:0]        ax_type = '0;
    logic              out_valid, out_ready = 1'b1, out_spike;
    logic signed [8:0] out_potential;

    always #5 clk = ~clk;

    lif_neuron_engine #(
        .LEAK_WIDTH(9), .WEIGHT_WIDTH(9), .THRESHOLD_WIDTH(9),
        .POTENTIAL_WIDTH(9), .NUM_WEIGHTS(4), .NEG_RESET_MODE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_potential(cfg_potential), .cfg_leak(cfg_leak), .cfg_weights(cfg_weights),
        .cfg_pos_threshold(cfg_pos_threshold), .cfg_neg_threshold(cfg_neg_threshold),
        .cfg_reset_potential(cfg_reset_potential), .cfg_reset_mode(cfg_reset_mode),
        .ax_valid(ax_valid), .ax_ready(ax_ready), .ax_type(ax_type),
        .ax_spike(ax_spike), .ax_last(ax_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_potential(out_potential), .out_spike(out_spike)
    );

    typedef struct packed {
        logic signed [8:0] pot;
        logic [35:0]       w;
        logic [2:0]        nb;
        logic [3:0][1:0]   ty;
        logic [3:0]        sp;
        logic signed [8:0] leak;
        logic [8:0]        pos;
        logic [8:0]        neg;
        logic signed [8:0] rp;
        logic [1:0]        mode;
        logic signed [8:0] e_pot;
        logic              e_spk;
    } vec_t;

    typedef struct packed {
        logic signed [8:0] pot;
        logic              spk;
    } exp_t;

    localparam int NV = 13;
    localparam logic [35:0] W1 = {9'd5, 9'h1FD, 9'd7, 9'd0};
    vec_t vecs[NV];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input int pot, input logic [35:0] w, input int nb,
                                input int t0, input int t1, input int t2, input int t3,
                                input logic [3:0] sp, input int leak, input int pos, input int neg,
                                input int rp, input int mode, input int epot, input int espk);
        vec_t v;
        v.pot = 9'(pot); v.w = w; v.nb = 3'(nb);
        v.ty[0] = 2'(t0); v.ty[1] = 2'(t1); v.ty[2] = 2'(t2); v.ty[3] = 2'(t3);
        v.sp = sp; v.leak = 9'(leak); v.pos = 9'(pos); v.neg = 9'(neg);
        v.rp = 9'(rp); v.mode = 2'(mode); v.e_pot = 9'(epot); v.e_spk = 1'(espk);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, got 0, want 1", name);
    endtask

    // drives cfg then up to 'upto' beats; returns 1 time unit after the last beat's transfer edge
    task automatic send_job(input vec_t v, input int upto);
        int n;
        exp_t e;
        if (upto >= int'(v.nb)) begin
            e.pot = v.e_pot;
            e.spk = v.e_spk;
            sb.push_back(e);
        end
        cfg_valid = 1'b1; cfg_potential = v.pot; cfg_leak = v.leak; cfg_weights = v.w;
        cfg_pos_threshold = v.pos; cfg_neg_threshold = v.neg;
        cfg_reset_potential = v.rp; cfg_reset_mode = v.mode;
        n = 0;
        while (!cfg_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!cfg_ready) timeout("cfg_handshake");
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int i = 0; i < int'(v.nb) && i < upto; i++) begin
            ax_valid = 1'b1; ax_type = v.ty[i]; ax_spike = v.sp[i]; ax_last = (i == int'(v.nb) - 1);
            n = 0;
            while (!ax_ready && n < 20) begin @(posedge clk); #1; n++; end
            if (!ax_ready) timeout("ax_handshake");
            @(posedge clk); #1;
        end
        ax_valid = 1'b0; ax_last = 1'b0; ax_spike = 1'b0;
    endtask

    // waits for a result, compares it with the scoreboard head, then lets the transfer edge pass
    task automatic collect(input string tag);
        int n = 0;
        exp_t e;
        while (!(out_valid && out_ready) && n < 20) begin @(posedge clk); #1; n++; end
        if (!(out_valid && out_ready)) begin
            timeout({tag, " out_valid"});
            return;
        end
        if (sb.size() == 0) begin
            chk({tag, " unexpected_result"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, " out_potential"}, int'(out_potential), int'($signed(e.pot)));
            chk({tag, " out_spike"}, int'(out_spike), int'(e.spk));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic signed [8:0] held_pot;
        logic held_spk;
        int bad;
        vecs[0]  = mk(10,   W1, 3, 0, 1, 2, 0, 4'b0111, -1, 15, 100, 0, 0, 0, 1);
        vecs[1]  = mk(10,   W1, 3, 0, 1, 2, 0, 4'b0111, -1, 15, 100, 0, 1, 3, 1);
        vecs[2]  = mk(10,   W1, 3, 0, 1, 2, 0, 4'b0111, -1, 15, 100, 0, 2, 18, 1);
        vecs[3]  = mk(10,   W1, 3, 0, 1, 2, 0, 4'b0111, -1, 15, 100, -7, 3, -7, 1);
        vecs[4]  = mk(250,  {9'd100, 27'd0}, 2, 0, 0, 0, 0, 4'b0011, 0, 255, 100, 0, 2, 255, 1);
        vecs[5]  = mk(-20,  W1, 1, 0, 0, 0, 0, 4'b0000, -10, 15, 25, 0, 0, -25, 0);
        vecs[6]  = mk(-20,  W1, 1, 0, 0, 0, 0, 4'b0000, -10, 15, 30, 0, 0, -30, 0);
        vecs[7]  = mk(-250, {9'd412, 27'd0}, 2, 0, 0, 0, 0, 4'b0011, -5, 255, 255, 0, 0, -255, 0);
        vecs[8]  = mk(0,    W1, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 100, 0, 2, 0, 1);
        vecs[9]  = mk(5,    W1, 1, 3, 0, 0, 0, 4'b0001, 2, 15, 100, 0, 0, 7, 0);
        vecs[10] = mk(14,   W1, 1, 0, 0, 0, 0, 4'b0000, 1, 15, 100, 0, 1, 0, 1);
        vecs[11] = mk(10,   W1, 3, 0, 1, 2, 0, 4'b0101, -1, 15, 100, 0, 1, 6, 1);
        vecs[12] = mk(14,   W1, 1, 0, 0, 0, 0, 4'b0000, 0, 15, 100, 0, 0, 14, 0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset cfg_ready", int'(cfg_ready), 1);
        chk("reset ax_ready", int'(ax_ready), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_potential", int'(out_potential), 0);
        chk("reset out_spike", int'(out_spike), 0);

        for (int i = 0; i < NV; i++) begin
            send_job(vecs[i], 4);
            collect($sformatf("vec%0d", i));
        end

        // backpressure, exact latency, and cfg/ax ignored while holding a result
        out_ready = 1'b0;
        send_job(vecs[1], 4);
        chk("latency out_valid after t+0", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("latency out_valid after t+1", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("latency out_valid after t+2", int'(out_valid), 1);
        held_pot = out_potential;
        held_spk = out_spike;
        cfg_valid = 1'b1; ax_valid = 1'b1; ax_spike = 1'b1; ax_last = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (!out_valid || cfg_ready || ax_ready || out_potential != held_pot || out_spike != held_spk) bad++;
        end
        chk("backpressure hold violations", bad, 0);
        cfg_valid = 1'b0; ax_valid = 1'b0; ax_spike = 1'b0; ax_last = 1'b0;
        out_ready = 1'b1;
        collect("backpressure");
        chk("cfg_ready after out transfer", int'(cfg_ready), 1);

        // reset in the middle of integration discards the job
        send_job(vecs[0], 2);
        chk("mid-integ ax_ready", int'(ax_ready), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort cfg_ready", int'(cfg_ready), 1);
        chk("abort ax_ready", int'(ax_ready), 0);
        chk("abort out_potential", int'(out_potential), 0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) bad++;
            @(posedge clk); #1;
        end
        chk("abort out_valid rises", bad, 0);
        send_job(vecs[0], 4);
        collect("after_abort");
        chk("scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
